dmem_arbiter: RTL and testbench

Shares the single-ported data memory between the processor pipeline's memory-access stage and an external requester (DMA/NIC loader). Each cycle the block grants the memory port to at most one requester, drives the DMEM control/address/data pins, and stalls the pipeline when it loses arbitration. It routes the one-cycle-late read data back to the requester that issued the read. With fairness enabled, a starvation counter bounds how long the external side can be locked out.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-ported data memory between the pipeline's memory-access
//   stage (CPU side) and an external requester (DMA / NIC loader).
//   - Each cycle at most one requester is granted.
//   - The grant decision is combinational. DMEM samples the pins at the next
//     rising edge.
//   - Read data comes back one cycle after the grant. It is steered to the
//     requester that issued the read, using a registered response tag.
//
//   Optional feature, enabled by defining DMEM_ARB_FAIRNESS_EN:
//   - A 4-bit starvation counter tracks how many contended cycles the
//     external side has lost.
//   - When it reaches MAX_WAIT, the external side is forced a one-cycle grant.
//   - Without the macro the CPU has strict priority and MAX_WAIT is unused.
//
// Parameters
//   DATA_WIDTH  memory word width
//   ADDR_WIDTH  DMEM address width
//   MAX_WAIT    contended cycles EXT may lose before a forced grant (1..15)
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata    pipeline request, held stable while stalled
//   cpu_stall                pipeline request not granted this cycle
//   cpu_rvalid/cpu_rdata     load response, one cycle after a granted load
//   ext_req/we/addr/wdata    external request, held stable until ext_gnt
//   ext_gnt                  external request accepted this cycle
//   ext_rvalid/ext_rdata     read response, one cycle after a granted read
//   dmem_address/dmem_dataIn DMEM address / write data (0 when idle)
//   store_enable/mem_enable  DMEM write strobe / access strobe
//   dmem_dataOut             DMEM read data, valid one cycle after access
module dmem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic [ADDR_WIDTH-1:0] dmem_address,
  output logic [DATA_WIDTH-1:0] dmem_dataIn,
  output logic                  store_enable,
  output logic                  mem_enable,
  input  logic [DATA_WIDTH-1:0] dmem_dataOut
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  owner_e rd_owner_q, rd_owner_d;
  logic   cpu_granted;
  logic   ext_granted;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       force_ext;

  // wait_cnt is only non-zero while ext_req is held. So reaching MAX_WAIT
  // already implies a standing external request.
  assign force_ext = (wait_cnt_q == MAX_WAIT_C);

  always_comb begin
    cpu_granted = cpu_req & ~(ext_req & force_ext);
    ext_granted = ext_req & ~cpu_granted;
  end

  // Count contended losses. Saturate at MAX_WAIT so the forced grant holds
  // until taken. Clear on a grant or when the request goes away.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!ext_req || ext_granted)
      wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_WAIT_C)
      wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`else
  // Strict CPU priority: the external side only gets idle CPU cycles.
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);

  always_comb begin
    cpu_granted = cpu_req;
    ext_granted = ext_req & ~cpu_req;
  end
`endif

  assign cpu_stall = cpu_req & ~cpu_granted;
  assign ext_gnt   = ext_req & ext_granted;

  // DMEM pin mux. Idle pins are driven to zero, not left at the last address.
  always_comb begin
    dmem_address = '0;
    dmem_dataIn  = '0;
    mem_enable   = 1'b0;
    store_enable = 1'b0;
    if (cpu_granted) begin
      dmem_address = cpu_addr;
      dmem_dataIn  = cpu_wdata;
      mem_enable   = 1'b1;
      store_enable = cpu_we;
    end else if (ext_granted) begin
      dmem_address = ext_addr;
      dmem_dataIn  = ext_wdata;
      mem_enable   = 1'b1;
      store_enable = ext_we;
    end
  end

  // Response tag. It is reloaded every cycle, so back-to-back reads from
  // either side each get their own tag. Writes and idle cycles clear it.
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_granted && !cpu_we)
      rd_owner_d = OWN_CPU;
    else if (ext_granted && !ext_we)
      rd_owner_d = OWN_EXT;
  end

  // Reset clears the tag, which drops any read response still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_owner_q <= OWN_NONE;
    else      rd_owner_q <= rd_owner_d;
  end

  // DMEM output is registered inside the memory, so the data is passed
  // straight through. The non-owner side sees zero.
  assign cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign ext_rvalid = (rd_owner_q == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? dmem_dataOut : '0;
  assign ext_rdata  = ext_rvalid ? dmem_dataOut : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int MW = 4;
`ifdef DMEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic          cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
  logic [AW-1:0] cpu_addr = '0, ext_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, ext_wdata = '0;
  logic          cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, store_enable, mem_enable;
  logic [DW-1:0] cpu_rdata, ext_rdata, dmem_dataIn, dmem_dataOut;
  logic [AW-1:0] dmem_address;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .dmem_address(dmem_address), .dmem_dataIn(dmem_dataIn),
    .store_enable(store_enable), .mem_enable(mem_enable), .dmem_dataOut(dmem_dataOut)
  );

  // DMEM emulation, driven only by the DUT pins. It is preloaded while
  // init_phase is set.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] init_mem [256];
  logic [DW-1:0] dout = '0;
  logic          init_phase = 1'b1;
  assign dmem_dataOut = dout;

  always @(posedge clk) begin
    if (init_phase) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
    end else if (mem_enable) begin
      if (store_enable) mem[dmem_address[7:0]] <= dmem_dataIn;
      else              dout <= mem[dmem_address[7:0]];
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [256];
  int            lost = 0;
  int            pend = 0;
  logic [DW-1:0] pend_data = '0;
  bit            last_cg = 0, last_eg = 0;

  typedef struct {
    logic          stall, gnt, men, sen;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          cv, ev;
    logic [DW-1:0] cd, ed;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: one expectation record per driven cycle, compared at negedge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("grant", {126'd0, cpu_stall, ext_gnt}, {126'd0, e.stall, e.gnt});
      chk("pins", {30'd0, mem_enable, store_enable, dmem_address, dmem_dataIn},
                  {30'd0, e.men, e.sen, e.addr, e.din});
      chk("cpu_resp", {63'd0, cpu_rvalid, cpu_rdata}, {63'd0, e.cv, e.cd});
      chk("ext_resp", {63'd0, ext_rvalid, ext_rdata}, {63'd0, e.ev, e.ed});
    end
  end

  // Drive one cycle of requests. Called at a posedge; returns at the next.
  task automatic step(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input bit er, input bit ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    exp_t e;
    bit cg, eg;
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    // CPU wins unless fairness is on and EXT has already lost MW contended cycles.
    cg = cr && !(FAIR && er && lost >= MW);
    eg = er && !cg;
    e.stall = cr && !cg;
    e.gnt   = eg;
    e.men   = cg || eg;
    e.sen   = cg ? cw : (eg ? ew : 1'b0);
    e.addr  = cg ? ca : (eg ? ea : '0);
    e.din   = cg ? cd : (eg ? ed : '0);
    e.cv    = (pend == 1);
    e.ev    = (pend == 2);
    e.cd    = (pend == 1) ? pend_data : '0;
    e.ed    = (pend == 2) ? pend_data : '0;
    q.push_back(e);
    pend = 0;
    if (cg) begin
      if (cw) ref_mem[ca[7:0]] = cd;
      else begin pend = 1; pend_data = ref_mem[ca[7:0]]; end
    end else if (eg) begin
      if (ew) ref_mem[ea[7:0]] = ed;
      else begin pend = 2; pend_data = ref_mem[ea[7:0]]; end
    end
    if (er && !eg) lost = (lost < MW) ? lost + 1 : MW;
    else           lost = 0;
    last_cg = cg;
    last_eg = eg;
    @(posedge clk);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  logic [AW-1:0] A10, A20, A40, A50, A60, A70;
  logic [DW-1:0] BEEF, D1234;

  initial begin
    bit            rc, rcw, re, rew;
    logic [AW-1:0] rca, rea;
    logic [DW-1:0] rcd, red;

    A10 = 32'h10; A20 = 32'h20; A40 = 32'h40; A50 = 32'h50; A60 = 32'h60; A70 = 32'h70;
    BEEF = 64'hDEAD_BEEF; D1234 = 64'h1234;
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = {$urandom, $urandom};
      ref_mem[i]  = init_mem[i];
    end
    init_mem[32] = BEEF;
    ref_mem[32]  = BEEF;

    // Preload the memory and check the outputs while reset is held.
    @(posedge clk);
    #1 init_phase = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rvalid", {127'd0, cpu_rvalid}, 128'd0);
    chk("rst_ext_rvalid", {127'd0, ext_rvalid}, 128'd0);
    chk("rst_cpu_rdata", {64'd0, cpu_rdata}, 128'd0);
    chk("rst_ext_rdata", {64'd0, ext_rdata}, 128'd0);
    #2 rst = 1'b1;
    @(posedge clk);

    // Lone load at 0x10, then load of 0xDEADBEEF at 0x20.
    step(1, 0, A10, '0, 0, 0, '0, '0);
    step(1, 0, A20, '0, 0, 0, '0, '0);
    // EXT writes 0x1234 to 0x40; CPU reads it back on the next cycle.
    step(0, 0, '0, '0, 1, 1, A40, D1234);
    step(1, 0, A40, '0, 0, 0, '0, '0);
    idle();

    // Contention: both sides request for 10 cycles, then the CPU drops.
    repeat (10) step(1, 0, A50, '0, 1, 1, A60, 64'hA5A5);
    step(0, 0, '0, '0, 1, 0, A60, '0);
    idle();

    // Interleaved reads: CPU, EXT, CPU.
    step(1, 0, A20, '0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 0, A40, '0);
    step(1, 0, A60, '0, 0, 0, '0, '0);
    idle();

    // Reset mid-traffic with a load in flight and EXT partially starved.
    step(1, 0, A50, '0, 1, 0, A70, '0);
    step(1, 0, A50, '0, 1, 0, A70, '0);
    step(1, 0, A20, '0, 0, 0, '0, '0);
    #1 rst = 1'b0;
    cpu_req = 0; ext_req = 0;
    pend = 0; lost = 0;
    @(negedge clk);
    chk("rstmid_cpu_rvalid", {127'd0, cpu_rvalid}, 128'd0);
    chk("rstmid_cpu_rdata", {64'd0, cpu_rdata}, 128'd0);
    chk("rstmid_ext_rvalid", {127'd0, ext_rvalid}, 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    // After reset the starvation count restarts from zero.
    step(1, 0, A10, '0, 0, 0, '0, '0);
    repeat (6) step(1, 1, A50, 64'h77, 1, 0, A20, '0);
    idle();

    // Randomized traffic. A requester holds its fields until granted.
    rc = 0; re = 0; rcw = 0; rew = 0; rca = '0; rea = '0; rcd = '0; red = '0;
    for (int n = 0; n < 400; n++) begin
      if (!rc || last_cg) begin
        rc  = ($urandom_range(0, 9) < 7);
        rcw = $urandom_range(0, 1) == 1;
        rca = {24'd0, 8'($urandom)};
        rcd = {$urandom, $urandom};
      end
      if (!re || last_eg) begin
        re  = ($urandom_range(0, 9) < 6);
        rew = $urandom_range(0, 1) == 1;
        rea = {24'd0, 8'($urandom)};
        red = {$urandom, $urandom};
      end
      step(rc, rcw, rca, rcd, re, rew, rea, red);
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    chk("drain", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
